// File: rtl/data_mem_wait_ctrl_pkg.sv
// data_mem_wait_ctrl_pkg: bus widths, FSM encoding and latched-request record for the data memory wait-state bridge
package data_mem_wait_ctrl_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int SEL_W = 4;
  typedef enum logic [1:0] {
    MW_IDLE = 2'd0,
    MW_WAIT = 2'd1,
    MW_DONE = 2'd2
  } mw_state_e;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } mem_req_t;
  function automatic bit wait_cfg_ok(int wait_cycles, int cnt_w);
    return wait_cycles >= 1 && wait_cycles <= 15 && (1 << cnt_w) > wait_cycles;
  endfunction
endpackage

// File: rtl/data_mem_wait_ctrl_if.sv
// data_mem_wait_ctrl_if: data memory port (request out, read data back) shared by the CPU side and the RAM side
interface data_mem_wait_ctrl_if;
  import data_mem_wait_ctrl_pkg::*;
  logic              ce;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  modport master (output ce, we, addr, sel, wdata, input rdata);
  modport slave (input ce, we, addr, sel, wdata, output rdata);
endinterface

// File: rtl/data_mem_wait_ctrl.sv
// data_mem_wait_ctrl: latches one CPU load/store, holds it on the RAM port for WAIT_CYCLES clocks and stalls the pipeline meanwhile
module data_mem_wait_ctrl
  import data_mem_wait_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  data_mem_wait_ctrl_if.slave         cpu,
  data_mem_wait_ctrl_if.master        ram,
  output logic                        stallreq
);
  if (!wait_cfg_ok(WAIT_CYCLES, CNT_W)) begin : g_cfg_err
    $error("data_mem_wait_ctrl: WAIT_CYCLES=%0d must be 1..15 and below 2**CNT_W (CNT_W=%0d)", WAIT_CYCLES, CNT_W);
  end
  mw_state_e         state;
  mw_state_e         nxt;
  mem_req_t          req;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              in_wait;
  logic              last;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MW_IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state == MW_IDLE ? (cpu.ce ? MW_WAIT : MW_IDLE)
        : state == MW_WAIT ? (cnt == '0 ? MW_DONE : MW_WAIT)
        : MW_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req     <= '0;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      if (state == MW_IDLE && cpu.ce) begin
        req <= '{we: cpu.we, addr: cpu.addr, sel: cpu.sel, data: cpu.wdata};
        cnt <= CNT_W'(WAIT_CYCLES - 1);
      end
      if (in_wait && cnt != '0) cnt <= cnt - CNT_W'(1);
      if (last && !req.we) rdata_q <= ram.rdata;
    end
  end
  always_comb begin
    in_wait   = state == MW_WAIT;
    last      = in_wait && cnt == '0;
    stallreq  = state == MW_IDLE ? cpu.ce : in_wait;
    ram.ce    = in_wait;
    ram.we    = last && req.we;
    ram.addr  = in_wait ? req.addr : '0;
    ram.sel   = in_wait ? req.sel : '0;
    ram.wdata = in_wait ? req.data : '0;
    cpu.rdata = rdata_q;
  end
endmodule
